pipelined_reduction_or: RTL and testbench
=========================================

PIPELINED_REDUCTION_OR -- requirements
Module: pipelined_reduction_or

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8: number of decoder-slice inputs, legal range 1..64.
REQ-002 SHALL have parameter WIDTH, default 64: bit width of each input word and of the output word.
REQ-003 SHALL have parameter RADIX, default 4: fan-in of each tree node, legal range 2..8.
REQ-004 SHALL define NUM_STAGES = max(1, ceil(log_RADIX(NUM_INPUTS))).
REQ-005 SHALL have port clk_i, input, 1: the single clock, rising-edge active.
REQ-006 SHALL have port arst_i, input, 1: asynchronous reset, active-high.
REQ-007 SHALL have port flush_i, input, 1: synchronous pipeline flush.
REQ-008 SHALL have port valid_i, input, 1: input bundle valid.
REQ-009 SHALL have port ready_o, output, 1: input bundle accepted when valid_i && ready_o.
REQ-010 SHALL have port data_i, input, NUM_INPUTS x WIDTH: per-slice decoded words.
REQ-011 SHALL have port hit_i, input, NUM_INPUTS: per-slice match flags.
REQ-012 SHALL have port valid_o, output, 1: result valid.
REQ-013 SHALL have port ready_i, input, 1: downstream accepts when valid_o && ready_i.
REQ-014 SHALL have port data_o, output, WIDTH: bitwise OR of all NUM_INPUTS data_i words of one bundle.
REQ-015 SHALL have port multi_hit_o, output, 1: two or more hit_i bits were set in the bundle.
REQ-016 SHALL have port no_hit_o, output, 1: zero hit_i bits were set in the bundle.

Function
REQ-017 SHALL implement a RADIX-ary OR tree with one register rank per level, NUM_STAGES ranks in total, the last rank driving the outputs directly.
REQ-018 SHALL pad unused node inputs with zero data and zero hit count.
REQ-019 SHALL carry a 2-bit saturating hit count (0, 1, 2+) through each node alongside the data, with the node count = min(2, sum of child counts).
REQ-020 SHALL derive multi_hit_o = (count == 2) and no_hit_o = (count == 0) at the final rank, gated by valid_o.
REQ-021 SHALL give a latency of exactly NUM_STAGES cycles from acceptance to valid_o with no stall.
REQ-022 SHALL generate a global advance enable en = !valid_o || ready_i; all ranks shift together only when en is high.
REQ-023 SHALL drive ready_o = en && !flush_i combinationally.
REQ-024 SHALL hold data_o, multi_hit_o, no_hit_o and valid_o stable while valid_o && !ready_i.
REQ-025 SHALL load a bubble (valid 0, data 0, count 0) into rank 0 on an advance when valid_i is low.
REQ-026 SHALL force data_o, multi_hit_o and no_hit_o to 0 whenever valid_o is 0.
REQ-027 SHALL clear every rank's valid bit, data and count on the next edge when flush_i is high, regardless of ready_i; flush takes priority over acceptance and advance.
REQ-028 SHALL sustain a throughput of one bundle per cycle while ready_i stays high.
REQ-029 SHALL, for NUM_INPUTS = 1, pass data_i[0] and hit_i[0] through one register rank, with NUM_STAGES = 1.

Reset
REQ-030 SHALL, while arst_i is high, asynchronously force all rank valid bits, data and counts to 0, giving valid_o = 0, data_o = 0, multi_hit_o = 0, no_hit_o = 0 and ready_o = 1 (when flush_i is low).
REQ-031 SHALL discard all in-flight bundles when reset is asserted mid-operation, and SHALL begin accepting on the first rising edge after arst_i falls.

Verification
REQ-032 SHALL pass this scenario with NUM_INPUTS=8, WIDTH=16, RADIX=2, ready_i=1: data_i[k]=1<<k and hit_i=8'h04, accepted at cycle 0 -> valid_o at cycle 3, data_o=16'h00FF, multi_hit_o=0, no_hit_o=0.
REQ-033 SHALL pass this scenario with the same configuration: hit_i=8'h81 -> multi_hit_o=1; then hit_i=8'h00 -> no_hit_o=1 one cycle later.
REQ-034 SHALL pass this scenario: 10 back-to-back bundles with ready_i=1 -> 10 results on consecutive cycles, in order, values matching a reference OR model.
REQ-035 SHALL pass this scenario: ready_i held low for 5 cycles with the pipeline full -> ready_o=0, outputs stable and no bundle lost or duplicated after ready_i rises.
REQ-036 SHALL pass this scenario: flush_i pulsed for one cycle with 3 bundles in flight and valid_i=1 -> the bundle presented during the flush is not accepted, no flushed result appears, and valid_o=0 for the following 3 cycles.
REQ-037 SHALL pass this scenario: arst_i asserted asynchronously mid-stream -> valid_o and data_o go to 0 immediately, and the first bundle after release emerges after NUM_STAGES cycles.

Source files
------------

// File: rtl/pipelined_reduction_or.sv
// Pipelined RADIX-ary OR reduction of NUM_INPUTS decoder-slice words, with a
// saturating (0 / 1 / 2+) hit count carried alongside the data.
// Ports:
//   clk_i, arst_i         clock, asynchronous active-high reset
//   flush_i               synchronous clear of every rank
//   valid_i / ready_o     input bundle handshake (ready_o is combinational)
//   data_i, hit_i         per-slice words and match flags
//   valid_o / ready_i     result handshake
//   data_o                OR of all slice words of one bundle
//   multi_hit_o, no_hit_o two-or-more / zero hit flags of that bundle
module pipelined_reduction_or #(
   parameter int unsigned NUM_INPUTS = 8,
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned RADIX      = 4
) (
   input  logic                                clk_i,
   input  logic                                arst_i,
   input  logic                                flush_i,
   input  logic                                valid_i,
   output logic                                ready_o,
   input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    data_i,
   input  logic [NUM_INPUTS-1:0]               hit_i,
   output logic                                valid_o,
   input  logic                                ready_i,
   output logic [WIDTH-1:0]                    data_o,
   output logic                                multi_hit_o,
   output logic                                no_hit_o
);

   function automatic int unsigned f_pow(input int unsigned base, input int unsigned e);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < e; i++) p = p * base;
      return p;
   endfunction

   // Smallest stage count whose RADIX^stages covers all inputs (at least 1).
   function automatic int unsigned f_stages(input int unsigned n, input int unsigned r);
      int unsigned s;
      int unsigned p;
      s = 1;
      p = r;
      for (int i = 0; i < 8; i++) begin
         if (p < n) begin
            p = p * r;
            s = s + 1;
         end
      end
      return s;
   endfunction

   localparam int unsigned NUM_STAGES = f_stages(NUM_INPUTS, RADIX);
   localparam int unsigned NUM_LEAVES = f_pow(RADIX, NUM_STAGES);

   // Node storage is flattened: rank s occupies RADIX^(NUM_STAGES-1-s) slots
   // starting at f_off(s); the single last-rank node sits at the top index.
   function automatic int unsigned f_off(input int unsigned stage);
      int unsigned o;
      o = 0;
      for (int unsigned k = 0; k < stage; k++) o = o + f_pow(RADIX, NUM_STAGES - 1 - k);
      return o;
   endfunction

   localparam int unsigned TOTAL_NODES = f_off(NUM_STAGES);
   localparam int unsigned LAST        = TOTAL_NODES - 1;

   function automatic logic [WIDTH-1:0] f_or(input logic [RADIX-1:0][WIDTH-1:0] kids);
      logic [WIDTH-1:0] acc;
      acc = '0;
      for (int c = 0; c < int'(RADIX); c++) acc = acc | kids[c];
      return acc;
   endfunction

   // min(2, sum of child counts), saturating after every addition.
   function automatic logic [1:0] f_sat(input logic [RADIX-1:0][1:0] kids);
      logic [1:0] acc;
      logic [2:0] sum;
      acc = 2'd0;
      for (int c = 0; c < int'(RADIX); c++) begin
         sum = {1'b0, acc} + {1'b0, kids[c]};
         acc = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      end
      return acc;
   endfunction

   logic                                 w_en;
   logic                                 w_accept;
   logic [NUM_LEAVES-1:0][WIDTH-1:0]     w_leaf_data;
   logic [NUM_LEAVES-1:0][1:0]           w_leaf_cnt;
   logic [TOTAL_NODES-1:0][WIDTH-1:0]    w_next_data;
   logic [TOTAL_NODES-1:0][1:0]          w_next_cnt;
   logic [NUM_STAGES-1:0]                w_valid_in;
   logic [TOTAL_NODES-1:0][WIDTH-1:0]    r_data;
   logic [TOTAL_NODES-1:0][1:0]          r_cnt;
   logic [NUM_STAGES-1:0]                r_valid;

   // Global advance: every rank shifts together unless the output is stalled.
   assign w_en     = !r_valid[NUM_STAGES-1] || ready_i;
   assign ready_o  = w_en && !flush_i;
   assign w_accept = valid_i && ready_o;

   // Leaves are zero for padding slots and for bubbles, so rank 0 loads a
   // clean bubble whenever nothing is accepted.
   for (genvar i = 0; i < int'(NUM_LEAVES); i++) begin : g_leaf
      if (i < int'(NUM_INPUTS)) begin : g_used
         assign w_leaf_data[i] = w_accept ? data_i[i] : '0;
         assign w_leaf_cnt[i]  = {1'b0, w_accept & hit_i[i]};
      end else begin : g_pad
         assign w_leaf_data[i] = '0;
         assign w_leaf_cnt[i]  = 2'd0;
      end
   end

   // Tree nodes: each combines RADIX children from the previous rank.
   for (genvar s = 0; s < int'(NUM_STAGES); s++) begin : g_stage
      localparam int unsigned NODES = f_pow(RADIX, NUM_STAGES - 1 - s);
      localparam int unsigned OFF   = f_off(s);
      for (genvar n = 0; n < int'(NODES); n++) begin : g_node
         logic [RADIX-1:0][WIDTH-1:0] w_kid_data;
         logic [RADIX-1:0][1:0]       w_kid_cnt;
         for (genvar c = 0; c < int'(RADIX); c++) begin : g_kid
            if (s == 0) begin : g_from_leaf
               assign w_kid_data[c] = w_leaf_data[n*RADIX + c];
               assign w_kid_cnt[c]  = w_leaf_cnt[n*RADIX + c];
            end else begin : g_from_rank
               assign w_kid_data[c] = r_data[f_off(s - 1) + n*RADIX + c];
               assign w_kid_cnt[c]  = r_cnt[f_off(s - 1) + n*RADIX + c];
            end
         end
         assign w_next_data[OFF + n] = f_or(w_kid_data);
         assign w_next_cnt[OFF + n]  = f_sat(w_kid_cnt);
      end
      if (s == 0) begin : g_v0
         assign w_valid_in[s] = w_accept;
      end else begin : g_vn
         assign w_valid_in[s] = r_valid[s-1];
      end
   end

   // Rank registers: flush beats advance; stall holds everything.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_valid <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else if (flush_i) begin
         r_valid <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else if (w_en) begin
         r_valid <= w_valid_in;
         r_data  <= w_next_data;
         r_cnt   <= w_next_cnt;
      end
   end

   assign valid_o     = r_valid[NUM_STAGES-1];
   assign data_o      = r_data[LAST] & {WIDTH{valid_o}};
   assign multi_hit_o = valid_o && (r_cnt[LAST] == 2'd2);
   assign no_hit_o    = valid_o && (r_cnt[LAST] == 2'd0);

endmodule

// File: tb/tb_pipelined_reduction_or.sv
// Directed bench for pipelined_reduction_or (8 slices, 16-bit words, radix 2,
// three ranks).
module tb_pipelined_reduction_or;

   logic                 clk_i;
   logic                 arst_i;
   logic                 flush_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [7:0][15:0]     data_i;
   logic [7:0]           hit_i;
   logic                 valid_o;
   logic                 ready_i;
   logic [15:0]          data_o;
   logic                 multi_hit_o;
   logic                 no_hit_o;

   int n_cmp;
   int n_err;

   logic [7:0][15:0] bd [10];
   logic [7:0]       bh [10];
   logic [15:0]      ed [10];
   logic             em [10];
   logic             enh[10];

   pipelined_reduction_or #(.NUM_INPUTS(8), .WIDTH(16), .RADIX(2)) dut (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_i      (data_i),
      .hit_i       (hit_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .multi_hit_o (multi_hit_o),
      .no_hit_o    (no_hit_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_one(input int slot, input logic [15:0] v, input logic [7:0] h);
      data_i       = '0;
      data_i[slot] = v;
      hit_i        = h;
      valid_i      = 1'b1;
   endtask

   task automatic idle();
      valid_i = 1'b0;
      data_i  = '0;
      hit_i   = '0;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                          input logic m, input logic nh);
      chk({tag, ".valid"}, 32'(valid_o), 32'(v));
      chk({tag, ".data"},  32'(data_o),  32'(d));
      chk({tag, ".multi"}, 32'(multi_hit_o), 32'(m));
      chk({tag, ".nohit"}, 32'(no_hit_o),    32'(nh));
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      arst_i  = 1'b1;
      flush_i = 1'b0;
      ready_i = 1'b1;
      idle();

      // Reset state
      #2;
      chk_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("reset.ready", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      step();
      arst_i = 1'b0;

      // Single-hit, multi-hit and no-hit bundles back to back
      for (int k = 0; k < 8; k++) data_i[k] = 16'h0001 << k;
      hit_i = 8'h04; valid_i = 1'b1;
      #1;
      chk("a.ready", 32'(ready_o), 32'd1);
      chk("a.c0.valid", 32'(valid_o), 32'd0);
      step();
      for (int k = 0; k < 8; k++) data_i[k] = 16'h0100 << k;
      hit_i = 8'h81;
      chk("a.c1.valid", 32'(valid_o), 32'd0);
      step();
      for (int k = 0; k < 8; k++) data_i[k] = 16'h0001;
      hit_i = 8'h00;
      chk("a.c2.valid", 32'(valid_o), 32'd0);
      step();
      idle();
      chk_out("a.c3", 1'b1, 16'h00FF, 1'b0, 1'b0);
      step();
      chk_out("b.c4", 1'b1, 16'hFF00, 1'b1, 1'b0);
      step();
      chk_out("c.c5", 1'b1, 16'h0001, 1'b0, 1'b1);
      step();
      chk_out("drain", 1'b0, 16'h0000, 1'b0, 1'b0);

      // Ten back-to-back bundles against a reference OR model
      for (int i = 0; i < 10; i++) begin
         ed[i] = '0;
         for (int k = 0; k < 8; k++) begin
            bd[i][k] = 16'((i + 1) * 16'h0123 + k * 16'h1111);
            ed[i]    = ed[i] | bd[i][k];
         end
         case (i % 3)
            0:       bh[i] = 8'h00;
            1:       bh[i] = 8'(8'h01 << (i % 8));
            default: bh[i] = 8'(8'h03 << (i % 7));
         endcase
         em[i]  = ($countones(bh[i]) >= 2);
         enh[i] = (bh[i] == 8'h00);
      end
      for (int t = 0; t < 13; t++) begin
         if (t < 10) begin
            data_i = bd[t]; hit_i = bh[t]; valid_i = 1'b1;
         end else begin
            idle();
         end
         if (t >= 3) chk_out($sformatf("b2b%0d", t - 3), 1'b1, ed[t-3], em[t-3], enh[t-3]);
         step();
      end
      chk("b2b.end.valid", 32'(valid_o), 32'd0);

      // Stall with a full pipeline
      set_one(2, 16'hA5A5, 8'hFF); step();
      set_one(7, 16'h5A5A, 8'h00); step();
      set_one(0, 16'h1234, 8'h01); step();
      set_one(4, 16'hC3C3, 8'h10);
      ready_i = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d.ready", c), 32'(ready_o), 32'd0);
         chk_out($sformatf("stall%0d", c), 1'b1, 16'hA5A5, 1'b1, 1'b0);
         step();
      end
      ready_i = 1'b1;
      #1;
      chk("unstall.ready", 32'(ready_o), 32'd1);
      chk_out("p0", 1'b1, 16'hA5A5, 1'b1, 1'b0);
      step();
      idle();
      chk_out("p1", 1'b1, 16'h5A5A, 1'b0, 1'b1);
      step();
      chk_out("p2", 1'b1, 16'h1234, 1'b0, 1'b0);
      step();
      chk_out("p3", 1'b1, 16'hC3C3, 1'b0, 1'b0);
      step();
      chk_out("p.end", 1'b0, 16'h0000, 1'b0, 1'b0);

      // Flush with three bundles in flight and a fourth presented
      set_one(1, 16'h1111, 8'h02); step();
      set_one(3, 16'h2222, 8'h08); step();
      set_one(5, 16'h4444, 8'h20); step();
      set_one(6, 16'h8888, 8'h40);
      flush_i = 1'b1;
      #1;
      chk("flush.ready", 32'(ready_o), 32'd0);
      chk_out("flush.f0", 1'b1, 16'h1111, 1'b0, 1'b0);
      step();
      flush_i = 1'b0;
      idle();
      for (int c = 0; c < 3; c++) begin
         chk_out($sformatf("postflush%0d", c), 1'b0, 16'h0000, 1'b0, 1'b0);
         step();
      end
      chk("postflush3.valid", 32'(valid_o), 32'd0);

      // Asynchronous reset mid-stream
      set_one(0, 16'h0F0F, 8'h01); step();
      set_one(1, 16'hF0F0, 8'h03); step();
      set_one(2, 16'h00FF, 8'h00); step();
      idle();
      chk_out("prerst", 1'b1, 16'h0F0F, 1'b0, 1'b0);
      #2;
      arst_i = 1'b1;
      #1;
      chk_out("midrst", 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("midrst.ready", 32'(ready_o), 32'd1);
      step();
      arst_i = 1'b0;
      set_one(5, 16'hBEEF, 8'h20);
      step();
      idle();
      chk("rst.h1.valid", 32'(valid_o), 32'd0);
      step();
      chk("rst.h2.valid", 32'(valid_o), 32'd0);
      step();
      chk_out("rst.h3", 1'b1, 16'hBEEF, 1'b0, 1'b0);
      step();
      chk_out("rst.end", 1'b0, 16'h0000, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
